mips_mem_router: RTL and testbench

Parametrised, registered memory-bus router for the MIPS core. Accepts one read/write request per cycle on a valid/ready channel, decodes the address against NUM_REGIONS base/limit windows, forwards it through one pipeline register to the selected region with a rebased local address, and returns read data in request order. Unmapped or misaligned accesses never reach a region: reads return an error response in order, writes are dropped, and both latch a sticky fault record.

---
 rtl/mips_mem_router.sv | 220 ++++++++++++++++++++++
 tb/tb_mips_mem_router.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mem_router.sv
// Memory-bus router for the MIPS core: decodes each request against NUM_REGIONS
// base/limit windows, registers it toward one region and returns reads in order.

module mips_mem_router_win #(
  parameter int                ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BASE   = '0,
  parameter logic [ADDR_W-1:0] LIMIT  = '0,
  parameter logic [ADDR_W-1:0] BIAS   = '0
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [ADDR_W-1:0] loc_addr
);
  assign hit      = (addr >= BASE) && (addr <= LIMIT);
  assign loc_addr = addr - BASE + BIAS;
endmodule

module mips_mem_router #(
  parameter int NUM_REGIONS = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_OUTST   = 4,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE  =
    {32'hFFFF_0000, 32'h7FFF_0000, 32'h1001_0000, 32'h0040_0000},
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_LIMIT =
    {32'hFFFF_FFFF, 32'h7FFF_EFFC, 32'h1001_FFFF, 32'h004F_FFFF},
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BIAS  = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic [DATA_W-1:0]             req_wdata,
  output logic [NUM_REGIONS-1:0]        mem_valid,
  input  logic [NUM_REGIONS-1:0]        mem_ready,
  output logic                          mem_write,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [NUM_REGIONS-1:0]        mem_rsp_valid,
  output logic [NUM_REGIONS-1:0]        mem_rsp_ready,
  input  logic [NUM_REGIONS*DATA_W-1:0] mem_rsp_rdata,
  output logic                          rsp_valid,
  output logic                          rsp_err,
  output logic [DATA_W-1:0]             rsp_rdata,
  output logic                          err_flag,
  output logic [ADDR_W-1:0]             err_addr,
  output logic                          err_write,
  input  logic                          err_clr
);
  localparam int TAG_W = $clog2(NUM_REGIONS + 1);
  localparam int PTR_W = $clog2(MAX_OUTST);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [TAG_W-1:0] TAG_ERR = TAG_W'(NUM_REGIONS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);

  logic [NUM_REGIONS-1:0]             win_hit;
  logic [NUM_REGIONS-1:0][ADDR_W-1:0] win_addr;

  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_win
    mips_mem_router_win #(
      .ADDR_W (ADDR_W),
      .BASE   (REGION_BASE [g*ADDR_W +: ADDR_W]),
      .LIMIT  (REGION_LIMIT[g*ADDR_W +: ADDR_W]),
      .BIAS   (REGION_BIAS [g*ADDR_W +: ADDR_W])
    ) u_win (
      .addr     (req_addr),
      .hit      (win_hit[g]),
      .loc_addr (win_addr[g])
    );
  end

  logic [NUM_REGIONS-1:0] dec_oh;
  logic [TAG_W-1:0]       dec_idx;
  logic [ADDR_W-1:0]      dec_addr;
  logic                   req_fault;

  // Descending scan so the lowest matching window wins on overlap.
  always_comb begin
    dec_oh   = '0;
    dec_idx  = '0;
    dec_addr = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (win_hit[i]) begin
        dec_oh    = '0;
        dec_oh[i] = 1'b1;
        dec_idx   = TAG_W'(i);
        dec_addr  = win_addr[i];
      end
    end
  end

  assign req_fault = ~(|win_hit) | (req_addr[1:0] != 2'b00);

  logic [NUM_REGIONS-1:0] s_oh_q, s_oh_d;
  logic                   s_write_q, s_write_d;
  logic [ADDR_W-1:0]      s_addr_q, s_addr_d;
  logic [DATA_W-1:0]      s_wdata_q, s_wdata_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   err_flag_q, err_flag_d, err_write_q, err_write_d;
  logic [ADDR_W-1:0]      err_addr_q, err_addr_d;
  logic [TAG_W-1:0]       tag_mem_q [MAX_OUTST];

  logic s_busy, s_fire, accept, push, pop;
  logic [TAG_W-1:0] push_tag, head_tag;

  assign s_busy    = |s_oh_q;
  assign s_fire    = |(s_oh_q & mem_ready);
  assign req_ready = (~s_busy | s_fire) & (req_write | (cnt_q < CNT_MAX));
  assign accept    = req_valid & req_ready;
  assign push      = accept & ~req_write;
  assign push_tag  = req_fault ? TAG_ERR : dec_idx;
  assign head_tag  = tag_mem_q[rd_ptr_q];

  assign mem_valid = s_oh_q;
  assign mem_write = s_write_q;
  assign mem_addr  = s_addr_q;
  assign mem_wdata = s_wdata_q;

  always_comb begin
    s_oh_d    = s_fire ? '0 : s_oh_q;
    s_write_d = s_write_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    if (accept && !req_fault) begin
      s_oh_d    = dec_oh;
      s_write_d = req_write;
      s_addr_d  = dec_addr;
      s_wdata_d = req_wdata;
    end
  end

  // Head of the tag FIFO steers the response mux; error tags retire at once.
  always_comb begin
    mem_rsp_ready = '0;
    rsp_valid     = 1'b0;
    rsp_err       = 1'b0;
    rsp_rdata     = '0;
    pop           = 1'b0;
    if (cnt_q != '0) begin
      if (head_tag == TAG_ERR) begin
        rsp_valid = 1'b1;
        rsp_err   = 1'b1;
        pop       = 1'b1;
      end else begin
        for (int i = 0; i < NUM_REGIONS; i++) begin
          if (head_tag == TAG_W'(i)) begin
            mem_rsp_ready[i] = 1'b1;
            rsp_valid        = mem_rsp_valid[i];
            rsp_rdata        = mem_rsp_valid[i] ? mem_rsp_rdata[i*DATA_W +: DATA_W] : '0;
            pop              = mem_rsp_valid[i];
          end
        end
      end
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // A fault coinciding with err_clr is recorded over the clear.
  always_comb begin
    err_flag_d  = err_flag_q;
    err_addr_d  = err_addr_q;
    err_write_d = err_write_q;
    if (err_clr) begin
      err_flag_d  = 1'b0;
      err_addr_d  = '0;
      err_write_d = 1'b0;
    end
    if (accept && req_fault && (!err_flag_q || err_clr)) begin
      err_flag_d  = 1'b1;
      err_addr_d  = req_addr;
      err_write_d = req_write;
    end
  end

  assign err_flag  = err_flag_q;
  assign err_addr  = err_addr_q;
  assign err_write = err_write_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_oh_q      <= '0;
      s_write_q   <= 1'b0;
      s_addr_q    <= '0;
      s_wdata_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      err_flag_q  <= 1'b0;
      err_addr_q  <= '0;
      err_write_q <= 1'b0;
    end else begin
      s_oh_q      <= s_oh_d;
      s_write_q   <= s_write_d;
      s_addr_q    <= s_addr_d;
      s_wdata_q   <= s_wdata_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      err_flag_q  <= err_flag_d;
      err_addr_q  <= err_addr_d;
      err_write_q <= err_write_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) tag_mem_q[wr_ptr_q] <= push_tag;
  end
endmodule

// File: tb/tb_mips_mem_router.sv
// Bench for mips_mem_router: directed requests, per-region read model and an
// in-order response scoreboard consumed by a forked monitor.
module tb_mips_mem_router;
  localparam int NR = 4;
  localparam logic [31:0] K = 32'hDEADBEE7;

  logic          clk = 1'b0, rst;
  logic          req_valid, req_ready, req_write;
  logic [31:0]   req_addr, req_wdata;
  logic [NR-1:0] mem_valid, mem_ready, mem_rsp_valid, mem_rsp_ready;
  logic          mem_write;
  logic [31:0]   mem_addr, mem_wdata;
  logic [NR*32-1:0] mem_rsp_rdata;
  logic          rsp_valid, rsp_err, err_flag, err_write, err_clr;
  logic [31:0]   rsp_rdata, err_addr;
  logic [NR-1:0] rsp_en;

  always #5 clk = ~clk;

  mips_mem_router dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_ready(mem_rsp_ready), .mem_rsp_rdata(mem_rsp_rdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .err_flag(err_flag), .err_addr(err_addr), .err_write(err_write), .err_clr(err_clr)
  );

  // Region model: queues fired read addresses, answers local_addr ^ K when enabled.
  logic [31:0] rbuf [NR][16];
  int rhd [NR];
  int rtl [NR];

  always @(posedge clk) begin
    for (int r = 0; r < NR; r++) begin
      if (rst) begin
        rhd[r] <= 0;
        rtl[r] <= 0;
      end else begin
        if (mem_rsp_valid[r] && mem_rsp_ready[r]) rhd[r] <= rhd[r] + 1;
        if (mem_valid[r] && mem_ready[r] && !mem_write) begin
          rbuf[r][rtl[r] % 16] <= mem_addr;
          rtl[r] <= rtl[r] + 1;
        end
      end
    end
  end

  always_comb begin
    mem_rsp_valid = '0;
    mem_rsp_rdata = '0;
    for (int r = 0; r < NR; r++) begin
      mem_rsp_valid[r] = rsp_en[r] && (rhd[r] != rtl[r]);
      mem_rsp_rdata[r*32 +: 32] = rbuf[r][rhd[r] % 16] ^ K;
    end
  end

  typedef struct packed { logic err; logic [31:0] data; } exp_t;
  exp_t sbq[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) sbq.delete();
      else if (rsp_valid) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rsp_unexpected actual err=%0b data=%0h required=none", rsp_err, rsp_rdata);
        end else begin
          e = sbq.pop_front();
          chk("rsp_err", rsp_err, e.err);
          chk("rsp_rdata", rsp_rdata, e.data);
        end
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d);
    int n;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("accept_timeout", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic e, input logic [31:0] d);
    sbq.push_back(exp_t'({e, d}));
    send(1'b0, a, 32'h0);
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sbq.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic clr_pulse();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    mem_ready = '0; rsp_en = '0; err_clr = 1'b0;
    fork monitor(); join_none
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_mem_rsp_ready", mem_rsp_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_err", {err_flag, err_write, err_addr}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    @(posedge clk); #1;
    rst = 1'b0; mem_ready = '1; rsp_en = '1;

    // basic mapped read into the data region
    rd(32'h1001_0008, 1'b0, 32'hDEADBEEF);
    @(negedge clk);
    chk("rd_mem_valid", mem_valid, 4'b0010);
    chk("rd_mem_addr", mem_addr, 32'h8);
    chk("rd_mem_write", mem_write, 0);
    @(posedge clk); #1;
    drain();

    // unmapped write, second fault, clears
    send(1'b1, 32'h10, 32'h55);
    @(negedge clk);
    chk("uw_mem_valid", mem_valid, 0);
    chk("uw_err_flag", err_flag, 1);
    chk("uw_err_addr", err_addr, 32'h10);
    chk("uw_err_write", err_write, 1);
    @(posedge clk); #1;
    rd(32'h20, 1'b1, 32'h0);
    @(negedge clk);
    chk("errrd_rsp_valid", rsp_valid, 1);
    chk("errrd_rsp_err", rsp_err, 1);
    chk("fault2_err_addr", err_addr, 32'h10);
    chk("fault2_err_write", err_write, 1);
    @(posedge clk); #1;
    drain();
    clr_pulse();
    @(negedge clk);
    chk("clr_err", {err_flag, err_write, err_addr}, 0);
    @(posedge clk); #1;
    send(1'b1, 32'h24, 32'h0);
    err_clr = 1'b1;
    send(1'b1, 32'h28, 32'h0);
    err_clr = 1'b0;
    @(negedge clk);
    chk("clr_vs_fault_flag", err_flag, 1);
    chk("clr_vs_fault_addr", err_addr, 32'h28);
    @(posedge clk); #1;
    clr_pulse();

    // misaligned read between two stack reads
    rd(32'h7FFF_0010, 1'b0, 32'hDEADBEF7);
    rd(32'h7FFF_0002, 1'b1, 32'h0);
    rd(32'h7FFF_0020, 1'b0, 32'hDEADBEC7);
    @(negedge clk);
    chk("mis_err_addr", err_addr, 32'h7FFF_0002);
    chk("mis_err_write", err_write, 0);
    @(posedge clk); #1;
    drain();
    clr_pulse();

    // tag FIFO full: reads stall, writes flow
    rsp_en[2] = 1'b0;
    rd(32'h7FFF_0000, 1'b0, 32'hDEADBEE7);
    rd(32'h7FFF_0004, 1'b0, 32'hDEADBEE3);
    rd(32'h7FFF_0008, 1'b0, 32'hDEADBEEF);
    rd(32'h7FFF_000C, 1'b0, 32'hDEADBEEB);
    sbq.push_back(exp_t'({1'b0, 32'hDEADBEF7}));
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h7FFF_0010;
    @(negedge clk);
    chk("full_stall0", req_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("full_stall1", req_ready, 0);
    @(posedge clk); #1;
    req_write = 1'b1; req_addr = 32'h7FFF_0100; req_wdata = 32'h1234;
    @(negedge clk);
    chk("full_wr_ready", req_ready, 1);
    @(posedge clk); #1;
    req_write = 1'b0; req_addr = 32'h7FFF_0010; req_wdata = 32'h0;
    @(negedge clk);
    chk("full_wr_valid", mem_valid, 4'b0100);
    chk("full_wr_write", mem_write, 1);
    chk("full_wr_addr", mem_addr, 32'h100);
    chk("full_wr_wdata", mem_wdata, 32'h1234);
    chk("full_stall2", req_ready, 0);
    @(posedge clk); #1;
    rsp_en[2] = 1'b1;
    @(negedge clk);
    chk("no_pop_credit", req_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("after_pop_ready", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    drain();

    // backpressure from the region holds the stage register
    mem_ready = '0;
    send(1'b1, 32'h0040_0010, 32'hCAFEF00D);
    sbq.push_back(exp_t'({1'b0, 32'hDEADBEE3}));
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0040_0004; req_wdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_mem_valid", mem_valid, 4'b0001);
      chk("bp_mem_addr", mem_addr, 32'h10);
      chk("bp_mem_wdata", mem_wdata, 32'hCAFEF00D);
      chk("bp_req_ready", req_ready, 0);
      @(posedge clk); #1;
    end
    mem_ready = '1;
    @(negedge clk);
    chk("bp_fire_ready", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_valid", mem_valid, 4'b0001);
    chk("bp_next_write", mem_write, 0);
    chk("bp_next_addr", mem_addr, 32'h4);
    @(posedge clk); #1;
    drain();

    // asynchronous reset with S full and two tags outstanding
    rsp_en = '0;
    rd(32'h1001_0000, 1'b0, 32'hDEADBEE7);
    @(posedge clk); #1;
    mem_ready = '0;
    rd(32'h1001_0004, 1'b0, 32'hDEADBEE3);
    @(negedge clk);
    chk("pre_rst_mem_valid", mem_valid, 4'b0010);
    #2 rst = 1'b1;
    #1;
    chk("arst_req_ready", req_ready, 1);
    chk("arst_mem_valid", mem_valid, 0);
    chk("arst_mem_bus", {mem_write, mem_addr, mem_wdata}, 0);
    chk("arst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
    chk("arst_mem_rsp_ready", mem_rsp_ready, 0);
    chk("arst_err", {err_flag, err_write, err_addr}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; mem_ready = '1; rsp_en = '1;
    rd(32'h1001_0010, 1'b0, 32'hDEADBEF7);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
